// File: rtl/csoc_uart_pkg.sv
// Shared types and defaults for the CSoC UART transmit path.
// Holds the arbiter state encoding and parameter defaults.
package csoc_uart_pkg;

  localparam int NREQ_DEF         = 4;
  localparam int HOLD_TIMEOUT_DEF = 1024;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Searches i_req from i_rr_ptr upward with wrap.
module rr_pick
  import csoc_uart_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_rr_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [IW-1:0]   o_idx,
  output logic            o_any
);

  always_comb begin
    int k;
    k     = 0;
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      k = int'(i_rr_ptr) + i;
      if (k >= NREQ) k = k - NREQ;
      if (!o_any && i_req[k]) begin
        o_any    = 1'b1;
        o_gnt[k] = 1'b1;
        o_idx    = IW'(k);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NREQ byte streams.
// Round-robin grants, locked per packet until last byte or timeout.
module uart_tx_arbiter
  import csoc_uart_pkg::*;
#(
  parameter int NREQ         = NREQ_DEF,
  parameter int HOLD_TIMEOUT = HOLD_TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [NREQ-1:0]   req_i,
  input  logic [NREQ-1:0]   last_i,
  input  logic [8*NREQ-1:0] data_i,
  output logic [NREQ-1:0]   ack_o,
  output logic [NREQ-1:0]   grant_o,
  output logic              busy_o,
  output logic              timeout_o,
  output logic              tx_start_o,
  output logic [7:0]        tx_data_o,
  input  logic              tx_ready_i
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(HOLD_TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_TIMEOUT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NREQ - 1);

  arb_state_t      r_state;
  logic [IW-1:0]   r_rr;
  logic [IW-1:0]   r_g;
  logic            r_last;
  logic [CW-1:0]   r_cnt;
  logic [NREQ-1:0] r_grant;
  logic [NREQ-1:0] r_ack;
  logic            r_start;
  logic            r_timeout;
  logic [7:0]      r_data;

  logic [NREQ-1:0] w_gnt;
  logic [IW-1:0]   w_idx;
  logic            w_any;
  logic [7:0]      w_pick_data;
  logic [7:0]      w_own_data;
  logic            w_own_req;
  logic [IW-1:0]   w_next_rr;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .i_req    (req_i),
    .i_rr_ptr (r_rr),
    .o_gnt    (w_gnt),
    .o_idx    (w_idx),
    .o_any    (w_any)
  );

  assign w_pick_data = data_i[8*w_idx +: 8];
  assign w_own_data  = data_i[8*r_g +: 8];
  assign w_own_req   = req_i[r_g];
  assign w_next_rr   = (r_g == IDX_LAST) ? '0 : r_g + IW'(1);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state   <= ST_IDLE;
      r_rr      <= '0;
      r_g       <= '0;
      r_last    <= 1'b0;
      r_cnt     <= '0;
      r_grant   <= '0;
      r_ack     <= '0;
      r_start   <= 1'b0;
      r_timeout <= 1'b0;
      r_data    <= 8'h00;
    end else begin
      r_ack     <= '0;
      r_start   <= 1'b0;
      r_timeout <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          // a busy transmitter is never restarted
          if (tx_ready_i && w_any) begin
            r_g     <= w_idx;
            r_data  <= w_pick_data;
            r_last  <= last_i[w_idx];
            r_grant <= w_gnt;
            r_ack   <= w_gnt;
            r_start <= 1'b1;
            r_state <= ST_START;
          end
        end
        ST_START: r_state <= ST_WAIT;
        ST_WAIT: begin
          if (tx_ready_i) begin
            if (r_last) begin
              r_state <= ST_IDLE;
              r_grant <= '0;
              r_rr    <= w_next_rr;
            end else begin
              r_state <= ST_HOLD;
              r_cnt   <= '0;
            end
          end
        end
        ST_HOLD: begin
          if (w_own_req) begin
            r_data  <= w_own_data;
            r_last  <= last_i[r_g];
            r_ack   <= r_grant;
            r_start <= 1'b1;
            r_state <= ST_START;
          end else if (r_cnt == CNT_LAST) begin
            r_state   <= ST_IDLE;
            r_timeout <= 1'b1;
            r_grant   <= '0;
            r_rr      <= w_next_rr;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ack_o      = r_ack;
  assign grant_o    = r_grant;
  assign busy_o     = (r_state != ST_IDLE);
  assign timeout_o  = r_timeout;
  assign tx_start_o = r_start;
  assign tx_data_o  = r_data;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter.
// Queue-driven requesters and a stub transmitter busy BUSY cycles.
module tb_uart_tx_arbiter;

  localparam int N    = 4;
  localparam int HT   = 16;
  localparam int BUSY = 10;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic [N-1:0]   req_i = '0;
  logic [N-1:0]   last_i = '0;
  logic [8*N-1:0] data_i = '0;
  logic [N-1:0]   ack_o;
  logic [N-1:0]   grant_o;
  logic           busy_o;
  logic           timeout_o;
  logic           tx_start_o;
  logic [7:0]     tx_data_o;
  logic           tx_ready_i;

  logic stub_rdy = 1'b1;
  int   stub_cnt = 0;
  logic force_low = 1'b0;

  assign tx_ready_i = stub_rdy & ~force_low;

  uart_tx_arbiter #(
    .NREQ         (N),
    .HOLD_TIMEOUT (HT)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req_i      (req_i),
    .last_i     (last_i),
    .data_i     (data_i),
    .ack_o      (ack_o),
    .grant_o    (grant_o),
    .busy_o     (busy_o),
    .timeout_o  (timeout_o),
    .tx_start_o (tx_start_o),
    .tx_data_o  (tx_data_o),
    .tx_ready_i (tx_ready_i)
  );

  always #5 clk = ~clk;

  // stub transmitter: drops ready the cycle after start
  always @(posedge clk) begin
    if (tx_start_o) begin
      stub_rdy <= 1'b0;
      stub_cnt <= BUSY;
    end else if (stub_cnt > 0) begin
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt == 1) stub_rdy <= 1'b1;
    end
  end

  logic [8:0] q[N][$];
  int         log_g[$];
  logic [7:0] log_d[$];
  logic [N-1:0] log_a[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int ack_cnt[N];
  int to_cyc = -1;
  int to_cnt = 0;

  typedef struct {
    logic [N-1:0] mask;
    int           g;
  } vec_t;
  vec_t tv[12];

  function automatic int oh2i(logic [N-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < N; i++)
      if (v == N'(1 << i)) r = i;
    return r;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (tx_start_o) begin
      log_g.push_back(oh2i(grant_o));
      log_d.push_back(tx_data_o);
      log_a.push_back(ack_o);
    end
    if (timeout_o) begin
      to_cnt++;
      to_cyc = cyc;
    end
    for (int k = 0; k < N; k++) begin
      if (ack_o[k]) begin
        ack_cnt[k]++;
        if (q[k].size() > 0) void'(q[k].pop_front());
      end
    end
    for (int k = 0; k < N; k++) begin
      if (q[k].size() > 0) begin
        req_i[k]         = 1'b1;
        last_i[k]        = q[k][0][8];
        data_i[8*k +: 8] = q[k][0][7:0];
      end else begin
        req_i[k]         = 1'b0;
        last_i[k]        = 1'b0;
        data_i[8*k +: 8] = 8'h00;
      end
    end
  endtask

  task automatic wait_start(int base, int budget, string nm);
    int n;
    n = 0;
    while (log_g.size() == base && n < budget) begin
      tick();
      n++;
    end
    chk(nm, 32'(log_g.size() > base), 32'd1);
  endtask

  task automatic wait_idle(int budget, string nm);
    int  n;
    logic pend;
    n = 0;
    pend = 1'b1;
    while (pend && n < budget) begin
      tick();
      n++;
      pend = busy_o;
      for (int k = 0; k < N; k++)
        if (q[k].size() > 0) pend = 1'b1;
    end
    chk(nm, 32'(pend), 32'd0);
  endtask

  initial begin
    int base, a0, c_r, tc0;
    logic seen_low;
    logic [7:0] pk[4];
    int pg[4];

    tv[0]  = '{4'b1111, 0};
    tv[1]  = '{4'b1111, 1};
    tv[2]  = '{4'b1111, 2};
    tv[3]  = '{4'b1111, 3};
    tv[4]  = '{4'b1111, 0};
    tv[5]  = '{4'b0001, 0};
    tv[6]  = '{4'b1001, 3};
    tv[7]  = '{4'b0110, 1};
    tv[8]  = '{4'b0010, 1};
    tv[9]  = '{4'b0100, 2};
    tv[10] = '{4'b1000, 3};
    tv[11] = '{4'b0101, 0};
    for (int k = 0; k < N; k++) ack_cnt[k] = 0;

    rstn = 1'b0;
    repeat (3) tick();
    chk("rst_grant", 32'(grant_o), 0);
    chk("rst_ack", 32'(ack_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_timeout", 32'(timeout_o), 0);
    chk("rst_start", 32'(tx_start_o), 0);
    chk("rst_data", 32'(tx_data_o), 0);
    rstn = 1'b1;
    tick();

    for (int i = 0; i < 12; i++) begin
      base = log_g.size();
      for (int k = 0; k < N; k++)
        if (tv[i].mask[k]) q[k].push_back({1'b1, 8'(16*i + k)});
      wait_start(base, 20, $sformatf("tbl%0d_start", i));
      for (int k = 0; k < N; k++) q[k].delete();
      if (log_g.size() > base) begin
        chk($sformatf("tbl%0d_grant", i), 32'(log_g[base]), 32'(tv[i].g));
        chk($sformatf("tbl%0d_ack", i), 32'(log_a[base]), 32'(1 << tv[i].g));
        chk($sformatf("tbl%0d_data", i), 32'(log_d[base]),
            32'(16*i + tv[i].g));
      end
      wait_idle(60, $sformatf("tbl%0d_idle", i));
    end

    base = log_g.size();
    a0 = ack_cnt[0];
    q[0].push_back({1'b0, 8'h41});
    q[0].push_back({1'b0, 8'h42});
    q[0].push_back({1'b1, 8'h43});
    wait_idle(200, "pkt3_idle");
    chk("pkt3_starts", 32'(log_g.size() - base), 3);
    chk("pkt3_acks", 32'(ack_cnt[0] - a0), 3);
    chk("pkt3_grant_end", 32'(grant_o), 0);
    if (log_g.size() - base == 3) begin
      for (int j = 0; j < 3; j++) begin
        chk($sformatf("pkt3_g%0d", j), 32'(log_g[base+j]), 0);
        chk($sformatf("pkt3_d%0d", j), 32'(log_d[base+j]), 32'(8'h41 + j));
      end
    end

    base = log_g.size();
    q[1].push_back({1'b0, 8'h51});
    q[1].push_back({1'b0, 8'h52});
    q[1].push_back({1'b1, 8'h53});
    wait_start(base, 20, "lock_first");
    q[2].push_back({1'b1, 8'h60});
    wait_idle(300, "lock_idle");
    chk("lock_starts", 32'(log_g.size() - base), 4);
    pk = '{8'h51, 8'h52, 8'h53, 8'h60};
    pg = '{1, 1, 1, 2};
    if (log_g.size() - base == 4) begin
      for (int j = 0; j < 4; j++) begin
        chk($sformatf("lock_g%0d", j), 32'(log_g[base+j]), 32'(pg[j]));
        chk($sformatf("lock_d%0d", j), 32'(log_d[base+j]), 32'(pk[j]));
      end
    end

    base = log_g.size();
    tc0 = to_cnt;
    q[3].push_back({1'b0, 8'h70});
    wait_start(base, 20, "to_start");
    seen_low = 1'b0;
    c_r = -1;
    for (int n = 0; n < 100 && to_cnt == tc0; n++) begin
      tick();
      if (!tx_ready_i) seen_low = 1'b1;
      if (seen_low && tx_ready_i && c_r < 0) c_r = cyc;
    end
    chk("to_seen", 32'(to_cnt - tc0), 1);
    chk("to_latency", 32'(to_cyc - c_r), 32'(HT + 1));
    chk("to_grant", 32'(grant_o), 0);
    chk("to_busy", 32'(busy_o), 0);
    tick();
    chk("to_pulse_w", 32'(timeout_o), 0);
    base = log_g.size();
    q[0].push_back({1'b1, 8'h80});
    q[3].push_back({1'b1, 8'h83});
    wait_idle(200, "to_next_idle");
    chk("to_next_n", 32'(log_g.size() - base), 2);
    if (log_g.size() - base == 2) begin
      chk("to_next_g0", 32'(log_g[base]), 0);
      chk("to_next_g1", 32'(log_g[base+1]), 3);
    end

    force_low = 1'b1;
    base = log_g.size();
    a0 = ack_cnt[2];
    q[2].push_back({1'b1, 8'h90});
    repeat (8) tick();
    chk("nrdy_nostart", 32'(log_g.size() - base), 0);
    chk("nrdy_noack", 32'(ack_cnt[2] - a0), 0);
    force_low = 1'b0;
    tick();
    chk("nrdy_start", 32'(tx_start_o), 1);
    chk("nrdy_data", 32'(tx_data_o), 32'h90);
    wait_idle(100, "nrdy_idle");

    base = log_g.size();
    q[1].push_back({1'b1, 8'hA1});
    wait_start(base, 20, "rstw_start");
    tick();
    rstn = 1'b0;
    force_low = 1'b1;
    tick();
    tick();
    chk("rstw_grant", 32'(grant_o), 0);
    chk("rstw_ack", 32'(ack_o), 0);
    chk("rstw_busy", 32'(busy_o), 0);
    chk("rstw_start", 32'(tx_start_o), 0);
    chk("rstw_timeout", 32'(timeout_o), 0);
    chk("rstw_data", 32'(tx_data_o), 0);
    rstn = 1'b1;
    base = log_g.size();
    q[2].push_back({1'b1, 8'hB2});
    repeat (15) tick();
    chk("rstw_nostart", 32'(log_g.size() - base), 0);
    force_low = 1'b0;
    tick();
    chk("rstw_start2", 32'(tx_start_o), 1);
    chk("rstw_data2", 32'(tx_data_o), 32'hB2);
    chk("rstw_grant2", 32'(grant_o), 32'b0100);
    chk("rstw_ack2", 32'(ack_o), 32'b0100);
    wait_idle(100, "rstw_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
